// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the RV32I core.
//
// On a start request it stalls the pipeline and walks registers
// 0..NUM_REGS-1 through a spare register-file read port. It streams them out
// as one frame: HEADER byte, 4*NUM_REGS data bytes (each register
// little-endian), then the XOR of all data bytes.
//
// Handshake: the stream uses strict valid/ready. A byte transfers on a rising
// edge where tx_valid & tx_ready. Once tx_valid is raised, tx_data and the FSM
// hold until that transfer. tx_valid never depends on tx_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   dump request, only looked at in IDLE
//   rd_addr    out  [4:0]  register-file read address
//   rd_data    in   [31:0] register-file read data (combinational)
//   stall_req  out  pipeline hold request
//   tx_data    out  [7:0]  stream byte
//   tx_valid   out  stream byte valid
//   tx_ready   in   sink ready
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at end of frame
//   state_dbg  out  [2:0]  current FSM state, for debug
module reg_dump #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        stall_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HEADER   = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_CHECKSUM = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  cur_byte;

  // Little-endian byte select out of the latched word.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    byte_d  = byte_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HEADER;
          idx_d   = 5'd0;
          byte_d  = 2'd0;
          csum_d  = 8'h00;
        end
      end
      S_HEADER: begin
        if (tx_ready) state_d = S_LOAD;
      end
      S_LOAD: begin
        // rd_addr already shows idx, so rd_data is the register to send.
        word_d  = rd_data;
        byte_d  = 2'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (tx_ready) begin
          csum_d = csum_q ^ cur_byte;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_CHECKSUM;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_CHECKSUM: begin
        if (tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      word_q  <= 32'h0;
      byte_q  <= 2'd0;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
    end
  end

  // All outputs decode registered state only.
  assign rd_addr   = idx_q;
  assign tx_valid  = (state_q == S_HEADER) || (state_q == S_DATA) ||
                     (state_q == S_CHECKSUM);
  assign stall_req = (state_q == S_HEADER) || (state_q == S_LOAD) ||
                     (state_q == S_DATA)   || (state_q == S_CHECKSUM);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_HEADER:   tx_data = HEADER;
      S_DATA:     tx_data = cur_byte;
      S_CHECKSUM: tx_data = csum_q;
      default:    tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: directed frames with reset, nominal, backpressure,
// start-while-busy, reset mid-frame and back-to-back cases.
module tb_reg_dump;

  localparam int FRAME_LEN = 130;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        stall_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  logic [31:0] regs [32];
  assign rd_data = regs[rd_addr];

  reg_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .stall_req (stall_req),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         gap_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   valid_cnt = 0;
  int   stall_drop = 0;
  int   unstable = 0;
  int   gap = 0;
  bit   gap_arm = 0;
  bit   hold_pend = 0;
  logic [7:0] held = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then observe what the DUT
  // shows for the cycle whose rising edge comes next.
  task automatic step(input logic rdy, input logic st);
    @(negedge clk);
    tx_ready = rdy;
    start    = st;
    #1;
    cyc++;
    if (tx_valid) valid_cnt++;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (hold_pend && (tx_data !== held)) unstable++;
    hold_pend = tx_valid && !tx_ready;
    held      = tx_data;
    if (busy && !done && !stall_req) stall_drop++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      gap      = 0;
      gap_arm  = 1;
    end else if (!busy) begin
      gap++;
    end else if (gap_arm) begin
      gap_q.push_back(gap);
      gap_arm = 0;
    end
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    return ($urandom_range(0, 99) < 30);
  endfunction

  task automatic clear_mon();
    got_q.delete();
    gap_q.delete();
    done_cnt   = 0;
    valid_cnt  = 0;
    stall_drop = 0;
    unstable   = 0;
    hold_pend  = 0;
    gap_arm    = 0;
  endtask

  // Run one frame from a start pulse until done plus one idle cycle.
  // busy_pulse_at >= 0 re-pulses start once that many bytes have transferred.
  task automatic run_frame(input string tag, input int mode,
                           input int busy_pulse_at, output int latency);
    int  start_cyc;
    bit  pulsed;
    int  n;
    clear_mon();
    pulsed = 0;
    step(pick_ready(mode), 1'b1);
    start_cyc = cyc;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      if (!pulsed && busy_pulse_at >= 0 && got_q.size() == busy_pulse_at) begin
        step(pick_ready(mode), 1'b1);
        pulsed = 1;
      end else begin
        step(pick_ready(mode), 1'b0);
      end
      n++;
    end
    check_val({tag, "_finished"}, 32'(done_cnt != 0), 32'd1);
    latency = done_cyc - start_cyc;
    step(1'b1, 1'b0);
    check_val({tag, "_idle_after_done"}, 32'(busy), 32'd0);
  endtask

  task automatic cmp_frame(input string tag, input int offset);
    if (got_q.size() >= offset + FRAME_LEN) begin
      for (int i = 0; i < FRAME_LEN; i++)
        check_val($sformatf("%s_byte%0d", tag, i), 32'(got_q[offset + i]),
                  32'(exp_q[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    check_val({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check_val({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check_val({tag, "_stall_req"}, 32'(stall_req), 32'd0);
    check_val({tag, "_busy"},      32'(busy),      32'd0);
    check_val({tag, "_done"},      32'(done),      32'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] cs;

    reset    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[2]  = 32'h0000_8000;
    regs[10] = 32'h1234_5678;

    // Expected frame built from the register image.
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(regs[r][8*b +: 8]);
        cs ^= regs[r][8*b +: 8];
      end
    end
    exp_q.push_back(cs);

    // Reset and idle
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    repeat (20) step(1'b1, 1'b0);
    check_val("idle_no_valid", 32'(valid_cnt), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Nominal frame, hand values
    run_frame("nominal", 0, -1, lat);
    check_val("nominal_len", 32'(got_q.size()), 32'(FRAME_LEN));
    if (got_q.size() == FRAME_LEN) begin
      check_val("nominal_header", 32'(got_q[0]),   32'hA5);
      check_val("nominal_x2_b0",  32'(got_q[9]),   32'h00);
      check_val("nominal_x2_b1",  32'(got_q[10]),  32'h80);
      check_val("nominal_x2_b2",  32'(got_q[11]),  32'h00);
      check_val("nominal_x2_b3",  32'(got_q[12]),  32'h00);
      check_val("nominal_x10_b0", 32'(got_q[41]),  32'h78);
      check_val("nominal_x10_b1", 32'(got_q[42]),  32'h56);
      check_val("nominal_x10_b2", 32'(got_q[43]),  32'h34);
      check_val("nominal_x10_b3", 32'(got_q[44]),  32'h12);
      check_val("nominal_csum",   32'(got_q[129]), 32'h88);
    end
    cmp_frame("nominal", 0);
    check_val("nominal_done_latency", 32'(lat), 32'd163);
    check_val("nominal_done_count", 32'(done_cnt), 32'd1);
    check_val("nominal_stall", 32'(stall_drop), 32'd0);

    // Backpressure
    run_frame("bp", 1, -1, lat);
    check_val("bp_len", 32'(got_q.size()), 32'(FRAME_LEN));
    cmp_frame("bp", 0);
    check_val("bp_data_stable", 32'(unstable), 32'd0);
    check_val("bp_stall", 32'(stall_drop), 32'd0);
    check_val("bp_done_count", 32'(done_cnt), 32'd1);

    // Start while busy, at data byte 50 (header + 50 bytes transferred)
    run_frame("busy_start", 0, 51, lat);
    repeat (20) step(1'b1, 1'b0);
    check_val("busy_start_len", 32'(got_q.size()), 32'(FRAME_LEN));
    check_val("busy_start_done_count", 32'(done_cnt), 32'd1);
    cmp_frame("busy_start", 0);

    // Reset during register 17
    clear_mon();
    step(1'b1, 1'b1);
    n = 0;
    while (!(busy && rd_addr == 5'd17) && n < 500) begin
      step(1'b1, 1'b0);
      n++;
    end
    check_val("midreset_reached_r17", 32'(rd_addr), 32'd17);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    repeat (10) step(1'b1, 1'b0);
    check_val("midreset_no_valid", 32'(valid_cnt), 32'd0);
    check_val("midreset_no_done", 32'(done_cnt), 32'd0);
    run_frame("restart", 0, -1, lat);
    check_val("restart_len", 32'(got_q.size()), 32'(FRAME_LEN));
    cmp_frame("restart", 0);

    // Back-to-back with start held high
    clear_mon();
    repeat (400) step(1'b1, 1'b1);
    check_val("b2b_done_count", 32'(done_cnt), 32'd2);
    check_val("b2b_min_len", 32'(got_q.size() >= 2 * FRAME_LEN), 32'd1);
    cmp_frame("b2b_f0", 0);
    cmp_frame("b2b_f1", FRAME_LEN);
    check_val("b2b_gap_seen", 32'(gap_q.size() >= 1), 32'd1);
    if (gap_q.size() >= 1) check_val("b2b_gap", 32'(gap_q[0]), 32'd1);
    n = 0;
    while (busy && n < 1000) begin
      step(1'b1, 1'b0);
      n++;
    end
    check_val("b2b_drained", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
